// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation
// encodings, FSM state type and the counter-width helper.
package muldiv_pkg;

    // Operation encodings as presented on the op port.
    // op[1] selects divide, op[0] selects signed.
    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    // Counter width that can hold WIDTH-1, which is the longest iteration count.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the multiply/divide datapath (purely combinational).
//   multiply: acc = {partial_hi, multiplier_remaining}; adds opnd times the
//             low STEP multiplier bits into the high half, then shifts the
//             whole accumulator right by STEP.
//   divide:   acc = {remainder, dividend_remaining}; shifts one dividend bit
//             into the remainder, trial-subtracts the divisor and restores on
//             borrow, shifting the quotient bit in at the bottom.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic                 div_mode,
    input  logic [2*WIDTH-1:0]   acc,
    input  logic [WIDTH-1:0]     opnd,
    output logic [2*WIDTH-1:0]   acc_next
);

    // ---------------- multiply: radix-2^STEP partial-product add ----------
    // Running sum of the high half plus each selected shifted multiplicand.
    // It cannot overflow WIDTH+STEP bits: hi < 2^W and the added partial
    // product is at most (2^W-1)*(2^STEP-1).
    logic [WIDTH+STEP-1:0] pp_sum [0:STEP];
    logic [2*WIDTH-1:0]    mul_next;

    assign pp_sum[0] = {{STEP{1'b0}}, acc[2*WIDTH-1:WIDTH]};

    generate
        for (genvar gi = 0; gi < STEP; gi++) begin : g_pp
            assign pp_sum[gi+1] = pp_sum[gi]
                                + (acc[gi] ? ({{STEP{1'b0}}, opnd} << gi)
                                           : {(WIDTH+STEP){1'b0}});
        end
    endgenerate

    assign mul_next = {pp_sum[STEP], acc[WIDTH-1:STEP]};

    // ---------------- divide: restoring, one bit per call -----------------
    logic [WIDTH:0]     shifted;
    logic [WIDTH+1:0]   trial;
    logic               q_bit;
    logic [WIDTH-1:0]   rem_new;
    logic [WIDTH-1:0]   quo_new;
    logic               div_unused;

    assign shifted    = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign trial      = {1'b0, shifted} - {2'b00, opnd};
    assign q_bit      = ~trial[WIDTH+1];
    // On success the difference is below the divisor, so bit WIDTH is zero.
    assign div_unused = trial[WIDTH];
    assign rem_new    = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    assign quo_new    = {acc[WIDTH-2:0], q_bit};

    assign acc_next = div_mode ? {rem_new, quo_new} : mul_next;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO result registers.
// Operands are reduced to magnitudes at launch, iterated through
// muldiv_step, then sign-corrected in the FIX state, which writes hi/lo.
// done pulses in the cycle after FIX, when hi/lo already hold the result.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [WIDTH-1:0]  srca,
    input  logic [WIDTH-1:0]  srcb,
    input  logic              hi_we,
    input  logic              lo_we,
    input  logic [WIDTH-1:0]  wdata,
    output logic              busy,
    output logic              done,
    output logic [WIDTH-1:0]  hi,
    output logic [WIDTH-1:0]  lo
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam int N_MUL = WIDTH / STEP;
    localparam logic [CNT_W-1:0] CNT_MUL_LOAD = CNT_W'(N_MUL - 1);
    localparam logic [CNT_W-1:0] CNT_DIV_LOAD = CNT_W'(WIDTH - 1);

    state_t               state_reg, state_next;
    logic [CNT_W-1:0]     cnt_reg;
    logic [2*WIDTH-1:0]   acc_reg;
    logic [WIDTH-1:0]     opnd_reg;
    logic                 is_div_reg;
    logic                 neg_main_reg;   // negate product / quotient
    logic                 neg_rem_reg;    // negate remainder
    logic                 bzero_reg;      // divisor was zero
    logic [WIDTH-1:0]     hi_reg, lo_reg;
    logic                 done_reg;

    logic                 run_en;
    logic                 fix_en;
    logic                 accept;

    // ---------------- launch-time operand conditioning --------------------
    logic                 op_signed, op_div;
    logic                 a_neg, b_neg;
    logic [WIDTH-1:0]     a_mag, b_mag;

    assign op_signed = op[0];
    assign op_div    = op[1];
    assign a_neg     = op_signed & srca[WIDTH-1];
    assign b_neg     = op_signed & srcb[WIDTH-1];
    assign a_mag     = a_neg ? -srca : srca;
    assign b_mag     = b_neg ? -srcb : srcb;
    assign accept    = start && (state_reg == IDLE);

    // ---------------- iteration step --------------------------------------
    logic [2*WIDTH-1:0]   step_next;

    muldiv_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_step (
        .div_mode (is_div_reg),
        .acc      (acc_reg),
        .opnd     (opnd_reg),
        .acc_next (step_next)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: IDLE -> RUN on accepted start, RUN -> FIX at count 0.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (cnt_reg == '0) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs: busy through RUN and FIX, step enable, result write enable.
    always_comb begin
        busy   = 1'b0;
        run_en = 1'b0;
        fix_en = 1'b0;
        case (state_reg)
            RUN:     begin busy = 1'b1; run_en = 1'b1; end
            FIX:     begin busy = 1'b1; fix_en = 1'b1; end
            default: ;
        endcase
    end

    // Operand, accumulator and counter registers: load on launch, step in RUN.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg      <= '0;
            acc_reg      <= '0;
            opnd_reg     <= '0;
            is_div_reg   <= 1'b0;
            neg_main_reg <= 1'b0;
            neg_rem_reg  <= 1'b0;
            bzero_reg    <= 1'b0;
        end else if (accept) begin
            // Multiply iterates over the multiplier, divide over the dividend;
            // the other magnitude is the fixed step operand.
            cnt_reg      <= op_div ? CNT_DIV_LOAD : CNT_MUL_LOAD;
            acc_reg      <= {{WIDTH{1'b0}}, (op_div ? a_mag : b_mag)};
            opnd_reg     <= op_div ? b_mag : a_mag;
            is_div_reg   <= op_div;
            neg_main_reg <= a_neg ^ b_neg;
            neg_rem_reg  <= a_neg;
            bzero_reg    <= (srcb == '0);
        end else if (run_en) begin
            acc_reg      <= step_next;
            if (cnt_reg != '0) begin
                cnt_reg  <= cnt_reg - 1'b1;
            end
        end
    end

    // ---------------- sign correction --------------------------------------
    // With a zero divisor the restoring loop leaves the dividend magnitude as
    // remainder, so the remainder fixup restores srca; only the quotient
    // needs overriding to all-ones.
    logic [2*WIDTH-1:0]   prod_fixed;
    logic [WIDTH-1:0]     quo_fixed;
    logic [WIDTH-1:0]     rem_fixed;

    assign prod_fixed = neg_main_reg ? -acc_reg : acc_reg;
    assign quo_fixed  = bzero_reg    ? {WIDTH{1'b1}}
                      : (neg_main_reg ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0]);
    assign rem_fixed  = neg_rem_reg  ? -acc_reg[2*WIDTH-1:WIDTH]
                                     : acc_reg[2*WIDTH-1:WIDTH];

    // HI/LO: written by FIX, or by MTHI/MTLO only while idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_reg <= '0;
            lo_reg <= '0;
        end else if (fix_en) begin
            hi_reg <= is_div_reg ? rem_fixed : prod_fixed[2*WIDTH-1:WIDTH];
            lo_reg <= is_div_reg ? quo_fixed : prod_fixed[WIDTH-1:0];
        end else if (!busy) begin
            if (hi_we) hi_reg <= wdata;
            if (lo_we) lo_reg <= wdata;
        end
    end

    // done follows FIX by one cycle so it coincides with the updated hi/lo.
    always_ff @(posedge clk) begin
        if (reset) begin
            done_reg <= 1'b0;
        end else begin
            done_reg <= fix_en;
        end
    end

    assign done = done_reg;
    assign hi   = hi_reg;
    assign lo   = lo_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed testbench for muldiv_unit: one instance with STEP=1 and one with
// STEP=4, hand-computed expected results and latencies.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start1, start4;
    logic [1:0]  op;
    logic [31:0] srca, srcb;
    logic        hi_we, lo_we;
    logic [31:0] wdata;
    logic        busy1, done1, busy4, done4;
    logic [31:0] hi1, lo1, hi4, lo4;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(32), .STEP(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .op(op),
        .srca(srca), .srcb(srcb), .hi_we(hi_we), .lo_we(lo_we),
        .wdata(wdata), .busy(busy1), .done(done1), .hi(hi1), .lo(lo1)
    );

    muldiv_unit #(.WIDTH(32), .STEP(4)) dut4 (
        .clk(clk), .reset(reset), .start(start4), .op(op),
        .srca(srca), .srcb(srcb), .hi_we(1'b0), .lo_we(1'b0),
        .wdata(wdata), .busy(busy4), .done(done4), .hi(hi4), .lo(lo4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("check %-28s observed %h expected %h", tag, obs, exp);
    endtask

    // Drive one start for the selected instance; returns #1 after edge E.
    task automatic launch(input bit sel4, input logic [1:0] o,
                          input logic [31:0] a, input logic [31:0] b);
        op = o; srca = a; srcb = b;
        if (sel4) start4 = 1'b1; else start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0; start4 = 1'b0;
    endtask

    // Wait for done (k0 edges after E already elapsed), check latency,
    // results, busy and the single-cycle pulse.
    task automatic wait_done(input bit sel4, input int k0, input int lat,
                             input logic [31:0] eh, input logic [31:0] el,
                             input string tag);
        int k = k0;
        bit seen = 1'b0;
        while (!seen && k < 200) begin
            @(posedge clk); #1;
            k++;
            if (sel4 ? done4 : done1) seen = 1'b1;
        end
        chk({tag, " done_seen"}, 32'(seen), 32'd1);
        chk({tag, " latency"},   32'(k),    32'(lat));
        chk({tag, " hi"},   sel4 ? hi4 : hi1, eh);
        chk({tag, " lo"},   sel4 ? lo4 : lo1, el);
        chk({tag, " busy"}, 32'(sel4 ? busy4 : busy1), 32'd0);
    endtask

    task automatic check_pulse_end(input bit sel4, input string tag);
        @(posedge clk); #1;
        chk({tag, " done_drop"}, 32'(sel4 ? done4 : done1), 32'd0);
    endtask

    initial begin
        int dcount;
        reset = 1'b1; start1 = 1'b0; start4 = 1'b0; op = 2'b00;
        srca = '0; srcb = '0; hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        chk("reset busy", 32'(busy1), 32'd0);
        chk("reset done", 32'(done1), 32'd0);
        chk("reset hi",   hi1, 32'd0);
        chk("reset lo",   lo1, 32'd0);

        // 1. MULTU max*max, STEP=1: N=32, done after E+33
        launch(1'b0, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("multu busy", 32'(busy1), 32'd1);
        wait_done(1'b0, 0, 33, 32'hFFFF_FFFE, 32'h0000_0001, "multu max");
        check_pulse_end(1'b0, "multu max");

        // 2. MULT -7*3 on both radices
        launch(1'b0, 2'b01, 32'hFFFF_FFF9, 32'd3);
        wait_done(1'b0, 0, 33, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult -7*3 s1");
        launch(1'b1, 2'b01, 32'hFFFF_FFF9, 32'd3);
        wait_done(1'b1, 0, 9, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult -7*3 s4");
        check_pulse_end(1'b1, "mult s4");
        launch(1'b1, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(1'b1, 0, 9, 32'h0, 32'h1, "mult -1*-1 s4");
        launch(1'b1, 2'b00, 32'h0001_0000, 32'h0001_0000);
        wait_done(1'b1, 0, 9, 32'h1, 32'h0, "multu 2^16sq s4");
        launch(1'b1, 2'b00, 32'hFFFF_FFFF, 32'd2);
        wait_done(1'b1, 0, 9, 32'h1, 32'hFFFF_FFFE, "multu max*2 s4");

        // 3. Divides
        launch(1'b0, 2'b11, 32'hFFFF_FFF9, 32'd2);
        wait_done(1'b0, 0, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div -7/2");
        launch(1'b0, 2'b11, 32'd7, 32'hFFFF_FFFE);
        wait_done(1'b0, 0, 33, 32'h1, 32'hFFFF_FFFD, "div 7/-2");
        launch(1'b0, 2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(1'b0, 0, 33, 32'h0, 32'h8000_0000, "div min/-1");
        launch(1'b0, 2'b10, 32'd100, 32'd7);
        wait_done(1'b0, 0, 33, 32'd2, 32'd14, "divu 100/7");
        launch(1'b1, 2'b10, 32'hFFFF_FFFF, 32'h10);
        wait_done(1'b1, 0, 33, 32'hF, 32'h0FFF_FFFF, "divu max/16 s4");

        // 4. Divide by zero
        launch(1'b0, 2'b10, 32'd5, 32'd0);
        wait_done(1'b0, 0, 33, 32'd5, 32'hFFFF_FFFF, "divu 5/0");
        launch(1'b0, 2'b11, 32'hFFFF_FFFB, 32'd0);
        wait_done(1'b0, 0, 33, 32'hFFFF_FFFB, 32'hFFFF_FFFF, "div -5/0");

        // 5. start/MTHI while busy ignored; back-to-back start in done cycle
        launch(1'b0, 2'b10, 32'd9, 32'd4);
        op = 2'b00; srca = 32'd11; srcb = 32'd13;
        start1 = 1'b1; hi_we = 1'b1; wdata = 32'h1234;
        @(posedge clk); #1;
        start1 = 1'b0; hi_we = 1'b0;
        wait_done(1'b0, 1, 33, 32'd1, 32'd2, "divu 9/4 busy-ign");
        launch(1'b0, 2'b00, 32'd3, 32'd5);
        wait_done(1'b0, 0, 33, 32'd0, 32'd15, "b2b multu 3*5");

        // MTHI+MTLO together while idle
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h55;
        @(posedge clk); #1;
        hi_we = 1'b0; lo_we = 1'b0;
        chk("mthi+mtlo hi", hi1, 32'h55);
        chk("mthi+mtlo lo", lo1, 32'h55);

        // MTHI in the same cycle as start: write lands, then the op runs
        hi_we = 1'b1; wdata = 32'h77;
        launch(1'b0, 2'b00, 32'd2, 32'd3);
        hi_we = 1'b0;
        chk("mthi+start hi", hi1, 32'h77);
        chk("mthi+start busy", 32'(busy1), 32'd1);
        wait_done(1'b0, 0, 33, 32'd0, 32'd6, "mthi+start multu");

        // 6. Reset in RUN cycle 10 aborts without done
        launch(1'b0, 2'b10, 32'd1000, 32'd3);
        repeat (9) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort busy", 32'(busy1), 32'd0);
        chk("abort hi",   hi1, 32'd0);
        chk("abort lo",   lo1, 32'd0);
        dcount = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done1) dcount++;
        end
        chk("abort no done", 32'(dcount), 32'd0);
        lo_we = 1'b1; wdata = 32'hABCD;
        @(posedge clk); #1;
        lo_we = 1'b0;
        chk("mtlo after reset lo", lo1, 32'hABCD);
        chk("mtlo after reset hi", hi1, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
